// File: rtl/icb_ext_pkg.sv
// Shared definitions for the extended ICB bus (command, write-data and
// response channels with burst length).
//   - Width constants for the bus fields.
//   - Packed channel structs, split by direction: *_m_t fields are driven by
//     the master, *_s_t fields are driven by the slave.
//   - State enum of the slave-side bridge FSM.
package icb_ext_pkg;

  localparam int ICB_ADDR_W = 19;
  localparam int ICB_WIDTH  = 32;
  localparam int ICB_LEN_W  = 3;

  typedef struct packed {
    logic                  valid;
    logic [ICB_ADDR_W-1:0] addr;
    logic                  read;
    logic [ICB_LEN_W-1:0]  len;
  } icb_ext_cmd_m_t;

  typedef struct packed {
    logic                   valid;
    logic [ICB_WIDTH-1:0]   data;
    logic [ICB_WIDTH/8-1:0] mask;
  } icb_ext_wr_m_t;

  typedef struct packed {
    logic ready;
  } icb_ext_rsp_m_t;

  typedef struct packed {
    logic ready;
  } icb_ext_cmd_s_t;

  typedef struct packed {
    logic ready;
  } icb_ext_wr_s_t;

  typedef struct packed {
    logic                 valid;
    logic [ICB_WIDTH-1:0] rdata;
    logic                 err;
    logic                 last;
  } icb_ext_rsp_s_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_WRSP  = 2'd3
  } icb_state_e;

endpackage

// File: rtl/icb_sram_bytemask.sv
// Synchronous single-clock word memory, one read port and one write port.
//   clk    : clock
//   we     : write enable for the word at waddr
//   waddr  : write word index
//   wdata  : write data
//   wmask  : byte enables, 1 = byte is written
//   raddr  : read word index, sampled every rising edge
//   rdata  : registered read data (one-cycle latency)
// Contents are never reset.
module icb_sram_bytemask #(
  parameter int WIDTH = 32,
  parameter int AW    = 17
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wmask,
  input  logic [AW-1:0]      raddr,
  output logic [WIDTH-1:0]   rdata
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/icb_modport_bridge.sv
// Slave-side bridge terminating the extended ICB bus on an internal word SRAM.
// Ports:
//   clk, rst_n           : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   cmd_valid/ready      : command channel (cmd_addr byte address, cmd_read,
//                          cmd_len = beats-1)
//   wr_valid/ready       : write beat channel (wr_data, wr_mask byte enables)
//   rsp_valid/ready      : response channel (rsp_rdata, rsp_err, rsp_last)
// Handshake: on every channel a beat transfers on a rising edge where valid
// and ready are both 1; the bridge holds its response fields stable while
// rsp_valid=1 and rsp_ready=0.
// A command with cmd_addr[1:0] != 0 is flagged as an error: its writes are
// dropped, its reads return 0, and every response beat carries rsp_err=1.
module icb_modport_bridge
  import icb_ext_pkg::*;
#(
  parameter int ADDR_W = ICB_ADDR_W,
  parameter int WIDTH  = ICB_WIDTH,
  parameter int LEN_W  = ICB_LEN_W,
  parameter int MEM_AW = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic               cmd_read,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_mask,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_last
);

  icb_state_e          state_q, state_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;     // word index of the current beat
  logic [LEN_W-1:0]    cnt_q, cnt_d;     // beats remaining after the current one
  logic                err_q, err_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                wr_ready_q, wr_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_last_q, rsp_last_d;

  logic                cmd_hs, wr_hs, rsp_hs;
  logic [MEM_AW-1:0]   cmd_idx;
  logic [MEM_AW-1:0]   rd_addr;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_rdata;

  assign cmd_hs  = cmd_valid & cmd_ready_q;
  assign wr_hs   = wr_valid & wr_ready_q;
  assign rsp_hs  = rsp_valid_q & rsp_ready;
  assign cmd_idx = cmd_addr[MEM_AW+1:2];
  assign mem_we  = wr_hs & ~err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    // The SRAM re-reads the current index by default so a stalled read beat
    // keeps its data; it is steered to the next index on the edge that
    // retires a beat, which presents that beat one cycle later.
    rd_addr = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          idx_d   = cmd_idx;
          cnt_d   = cmd_len;
          err_d   = |cmd_addr[1:0];
          rd_addr = cmd_idx;
          state_d = cmd_read ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_hs) begin
          idx_d = idx_q + MEM_AW'(1);
          if (cnt_q == '0) state_d = ST_WRSP;
          else             cnt_d   = cnt_q - LEN_W'(1);
        end
      end
      ST_WRSP: begin
        if (rsp_hs) state_d = ST_IDLE;
      end
      ST_READ: begin
        if (rsp_hs) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            idx_d   = idx_q + MEM_AW'(1);
            rd_addr = idx_q + MEM_AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are derived from the next state.
    cmd_ready_d = (state_d == ST_IDLE);
    wr_ready_d  = (state_d == ST_WRITE);
    rsp_valid_d = (state_d == ST_READ) || (state_d == ST_WRSP);
    rsp_err_d   = rsp_valid_d & err_d;
    rsp_last_d  = (state_d == ST_WRSP) || ((state_d == ST_READ) && (cnt_d == '0));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  icb_sram_bytemask #(
    .WIDTH (WIDTH),
    .AW    (MEM_AW)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (wr_data),
    .wmask (wr_mask),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_last  = rsp_last_q;
  // Write responses and errored reads carry zero data.
  assign rsp_rdata = ((state_q == ST_READ) && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_icb_modport_bridge.sv
// Directed and randomized bench for icb_modport_bridge. The reference model
// is a sparse word memory indexed by word number; read expectations are
// queued as {err, last, data} before each read command is issued.
module tb_icb_modport_bridge;

  localparam int MEM_WORDS = 1 << 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [18:0] cmd_addr;
  logic        cmd_read;
  logic [2:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_last;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [int];
  logic [33:0] exp_q [$];
  logic [31:0] wd [8];
  logic [3:0]  wm [8];

  icb_modport_bridge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_read  (cmd_read),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input int unsigned addr, input int beat);
    return int'(((addr >> 2) + beat) % MEM_WORDS);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (m[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input int w);
    if (model_mem.exists(w)) return model_mem[w];
    return 32'hxxxx_xxxx;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cmd_issue(input int unsigned addr, input bit rd, input int len);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    cmd_valid = 1'b1;
    cmd_addr  = addr[18:0];
    cmd_read  = rd;
    cmd_len   = len[2:0];
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = cmd_ready;
      if (hs) chk("wr_ready_in_idle", {31'd0, wr_ready}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", {31'd0, hs}, 32'd1);
  endtask

  task automatic do_write(input int unsigned addr, input int len, input bit gaps);
    bit hs, got, err;
    int n, w;
    err = (addr % 4) != 0;
    cmd_issue(addr, 1'b0, len);
    for (int b = 0; b <= len; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b0;
        @(posedge clk); #1;
      end
      wr_valid = 1'b1;
      wr_data  = wd[b];
      wr_mask  = wm[b];
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 50) begin
        @(negedge clk);
        hs = wr_ready;
        @(posedge clk); #1;
        n++;
      end
      chk("wr_beat_accepted", {31'd0, hs}, 32'd1);
      w = word_of(addr, b);
      if (!err) model_mem[w] = merge(model_mem.exists(w) ? model_mem[w] : 32'd0, wd[b], wm[b]);
    end
    wr_valid  = 1'b0;
    rsp_ready = 1'($urandom_range(0, 1));
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("wrsp_rdata", rsp_rdata, 32'd0);
        chk("wrsp_err", {31'd0, rsp_err}, {31'd0, err});
        chk("wrsp_last", {31'd0, rsp_last}, 32'd1);
        got = rsp_ready;
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      n++;
    end
    chk("wrsp_seen", {31'd0, got}, 32'd1);
    rsp_ready = 1'b0;
  endtask

  // mode 0: rsp_ready held 1, mode 1: toggling 1/0, mode 2: random
  task automatic do_read(input int unsigned addr, input int len, input int mode);
    bit err;
    bit first;
    int n;
    logic [33:0] e;
    err = (addr % 4) != 0;
    exp_q.delete();
    for (int b = 0; b <= len; b++)
      exp_q.push_back({err, (b == len), err ? 32'd0 : model_rd(word_of(addr, b))});
    rsp_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    cmd_issue(addr, 1'b1, len);
    @(negedge clk);
    chk("rd_first_valid_latency", {31'd0, rsp_valid}, 32'd1);
    chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    first = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      if (!first) @(negedge clk);
      first = 1'b0;
      chk("rd_valid_no_bubble", {31'd0, rsp_valid}, 32'd1);
      if (rsp_valid) begin
        e = exp_q[0];
        chk("rd_data", rsp_rdata, e[31:0]);
        chk("rd_err", {31'd0, rsp_err}, {31'd0, e[33]});
        chk("rd_last", {31'd0, rsp_last}, {31'd0, e[32]});
        if (rsp_ready) void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
      n++;
      case (mode)
        1:       rsp_ready = ~rsp_ready;
        2:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b1;
      endcase
    end
    chk("rd_all_beats", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk("rd_no_extra_beat", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    chk({tag, "_wr_ready"},  {31'd0, wr_ready},  32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata,          32'd0);
    chk({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
    chk({tag, "_rsp_last"},  {31'd0, rsp_last},  32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int unsigned a;
    int          len;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_read = 1'b0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_mask = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Single write then read
    wd[0] = 32'hDEAD_BEEF; wm[0] = 4'hF;
    do_write(32'h100, 0, 1'b0);
    do_read(32'h100, 0, 0);

    // Byte mask merge
    wd[0] = 32'h1122_3344; wm[0] = 4'hF;
    do_write(32'h200, 0, 1'b0);
    wd[0] = 32'hAABB_CCDD; wm[0] = 4'h5;
    do_write(32'h200, 0, 1'b0);
    do_read(32'h200, 0, 0);

    // Burst of 8 beats, data 0..7
    for (int i = 0; i < 8; i++) begin wd[i] = i; wm[i] = 4'hF; end
    do_write(32'h400, 7, 1'b0);
    do_read(32'h400, 7, 0);

    // Backpressure on a 4-beat read
    do_read(32'h400, 3, 1);

    // Misaligned write leaves memory untouched; misaligned read gives zero
    wd[0] = 32'h5A5A_0001; wm[0] = 4'hF;
    do_write(32'h0, 0, 1'b0);
    wd[0] = 32'hFFFF_FFFF; wm[0] = 4'hF;
    do_write(32'h2, 0, 1'b0);
    do_read(32'h0, 0, 0);
    do_read(32'h2, 1, 0);

    // Wrap from the top word to word 0
    wd[0] = 32'hC0DE_0001; wd[1] = 32'hC0DE_0002; wm[0] = 4'hF; wm[1] = 4'hF;
    do_write(32'h7FFFC, 1, 1'b0);
    do_read(32'h7FFFC, 1, 0);
    do_read(32'h0, 0, 0);

    // Reset in the middle of a 4-beat write
    cmd_issue(32'h600, 1'b0, 3);
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1; wr_data = 32'h6000 + b; wr_mask = 4'hF;
      @(negedge clk);
      chk("midburst_wr_ready", {31'd0, wr_ready}, 32'd1);
      @(posedge clk); #1;
      model_mem[word_of(32'h600, b)] = 32'h6000 + b;
    end
    wr_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_outputs_zero("midburst_reset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("cmd_ready_after_midburst_reset", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    wd[0] = 32'h7777_1234; wm[0] = 4'hF;
    do_write(32'h700, 0, 1'b0);
    do_read(32'h700, 0, 0);

    // Randomized traffic inside a fully initialized 64-word window
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 8; i++) begin wd[i] = $urandom; wm[i] = 4'hF; end
      do_write(32'h1000 + blk * 32, 7, 1'b1);
    end
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 7);
      a   = 32'h1000 + $urandom_range(0, 63 - len) * 4;
      if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        do_read(a, len, $urandom_range(0, 2));
      end else begin
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; wm[i] = 4'($urandom_range(0, 15)); end
        do_write(a, len, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
